// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, owner ids, fetch access size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_SERVE = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Instruction fetches are always full-word reads.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests (MEM_ARB_RR_EN: round-robin).
// Latency: zero, pure combinational.
// Backpressure: none here; the loser is stalled by the parent's busywait.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  owner_t last_grant,
`endif
    input  logic   i_req,
    input  logic   d_req,
    output owner_t grant
);

`ifdef MEM_ARB_RR_EN
    // On contention favour the port that did not win last time; otherwise the lone requester.
    always_comb begin
        grant = OWN_D;
        if (i_req && d_req) begin
            grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (i_req) begin
            grant = OWN_I;
        end
    end
`else
    // Fixed priority: data path wins; fetch only wins when it asks alone.
    always_comb begin
        grant = (i_req && !d_req) ? OWN_I : OWN_D;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data memory between fetch and load/store ports; optional MEM_ARB_RR_EN round-robin.
// Latency: grant 1 cycle after request, >=2 SERVE cycles, 1 DONE cycle (data visible in DONE).
// Backpressure: requester busywait held high until its DONE cycle; watchdog aborts after TIMEOUT.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [2:0]        D_FUNCT3,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [2:0]        MEM_FUNCT3,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              ERR
);

    // Last counter value still allowed to wait; the edge leaving it aborts.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_t state, state_nxt;
    owner_t     owner, grant;
    logic [7:0] cnt;
    logic       i_req, d_req;
    logic       do_grant, do_complete, do_abort;

    // Read and write together is malformed and treated as no request at all.
    assign i_req = I_READ;
    assign d_req = D_READ ^ D_WRITE;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;

    // Remember who won most recently so contention alternates.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_grant <= OWN_I;
        end else if (do_grant) begin
            last_grant <= grant;
        end
    end

    mem_arb_pick u_pick (
        .last_grant (last_grant),
        .i_req      (i_req),
        .d_req      (d_req),
        .grant      (grant)
    );
`else
    mem_arb_pick u_pick (
        .i_req (i_req),
        .d_req (d_req),
        .grant (grant)
    );
`endif

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> SERVE on any request, SERVE -> DONE on completion or abort, DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:  if (i_req || d_req) state_nxt = ARB_SERVE;
            ARB_SERVE: if (do_complete || do_abort) state_nxt = ARB_DONE;
            ARB_DONE:  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // Control decodes; completion needs one full wait cycle so the memory sees a settled strobe.
    always_comb begin
        do_grant    = 1'b0;
        do_complete = 1'b0;
        do_abort    = 1'b0;
        unique case (state)
            ARB_IDLE:  do_grant = i_req || d_req;
            ARB_SERVE: begin
                if (cnt != 8'd0 && !MEM_BUSYWAIT) begin
                    do_complete = 1'b1;
                end else if (cnt == TO_LAST) begin
                    do_abort = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Busywait releases only for the owner during its DONE cycle.
    assign I_BUSYWAIT = i_req && !(state == ARB_DONE && owner == OWN_I);
    assign D_BUSYWAIT = d_req && !(state == ARB_DONE && owner == OWN_D);

    // Memory-side request registers, owner and watchdog counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            owner         <= OWN_I;
            cnt           <= 8'd0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_FUNCT3    <= 3'b000;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else if (do_grant) begin
            owner <= grant;
            cnt   <= 8'd0;
            if (grant == OWN_D) begin
                MEM_READ      <= D_READ;
                MEM_WRITE     <= D_WRITE;
                MEM_FUNCT3    <= D_FUNCT3;
                MEM_ADDRESS   <= D_ADDRESS;
                MEM_WRITEDATA <= D_WRITEDATA;
            end else begin
                MEM_READ      <= 1'b1;
                MEM_WRITE     <= 1'b0;
                MEM_FUNCT3    <= FUNCT3_WORD;
                MEM_ADDRESS   <= I_ADDRESS;
                MEM_WRITEDATA <= '0;
            end
        end else if (state == ARB_SERVE) begin
            if (do_complete || do_abort) begin
                MEM_READ  <= 1'b0;
                MEM_WRITE <= 1'b0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Return data to the owner only; abort returns zero and latches the sticky error.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            I_READDATA <= '0;
            D_READDATA <= '0;
            ERR        <= 1'b0;
        end else if (do_complete && MEM_READ) begin
            if (owner == OWN_I) I_READDATA <= MEM_READDATA;
            else                D_READDATA <= MEM_READDATA;
        end else if (do_abort) begin
            ERR <= 1'b1;
            if (owner == OWN_I) I_READDATA <= '0;
            else                D_READDATA <= '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scoreboard of expected completions, popped when a port's busywait drops.
// Memory model answers immediately unless mem_stall is set; watchdog instantiated with TIMEOUT=8.
// Contention expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        CLK, RESET;
    logic        I_READ, I_BUSYWAIT;
    logic [31:0] I_ADDRESS, I_READDATA;
    logic        D_READ, D_WRITE, D_BUSYWAIT;
    logic [2:0]  D_FUNCT3;
    logic [31:0] D_ADDRESS, D_WRITEDATA, D_READDATA;
    logic        MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ADDRESS, MEM_WRITEDATA, MEM_READDATA;
    logic        ERR;
    logic        mem_stall;
    logic [31:0] mem [0:63];

    typedef struct {
        bit          port;   // 0 = fetch, 1 = data
        bit          rd;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    logic [31:0] mod_i    = '0;
    logic [31:0] mod_d    = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .I_READ        (I_READ),
        .I_ADDRESS     (I_ADDRESS),
        .I_READDATA    (I_READDATA),
        .I_BUSYWAIT    (I_BUSYWAIT),
        .D_READ        (D_READ),
        .D_WRITE       (D_WRITE),
        .D_FUNCT3      (D_FUNCT3),
        .D_ADDRESS     (D_ADDRESS),
        .D_WRITEDATA   (D_WRITEDATA),
        .D_READDATA    (D_READDATA),
        .D_BUSYWAIT    (D_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_FUNCT3    (MEM_FUNCT3),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .ERR           (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign MEM_BUSYWAIT = mem_stall;
    assign MEM_READDATA = mem[MEM_ADDRESS[7:2]];

    // Word memory: preloaded while reset is held, written on an accepted store strobe.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'(k) * 32'h0101_0101;
            mem[4] <= 32'hDEADBEEF;
        end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
            mem[MEM_ADDRESS[7:2]] <= MEM_WRITEDATA;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input bit port);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_done", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sb_port", 32'(port), 32'(e.port));
            if (e.rd) begin
                if (port) mod_d = e.data;
                else      mod_i = e.data;
            end
            check("sb_rdata", port ? D_READDATA : I_READDATA, port ? mod_d : mod_i);
            check("sb_other_rdata", port ? I_READDATA : D_READDATA, port ? mod_i : mod_d);
        end
        n_done++;
    endtask

    // A port completes in the cycle its request is up while its busywait is down.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (I_READ && !I_BUSYWAIT) sb_pop(1'b0);
            if ((D_READ ^ D_WRITE) && !D_BUSYWAIT) sb_pop(1'b1);
        end
    end

    task automatic wait_done(input string tag, input int target);
        for (int k = 0; k < 80 && n_done < target; k++) begin
            @(negedge CLK); #1;
        end
        check(tag, 32'(n_done >= target), 32'd1);
    endtask

    task automatic run_txn(input string tag, input bit port, input bit rd,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [31:0] exp_data,
                           input int exp_busy, input int exp_serve);
        int target, busy_n, serve_n;
        sb_q.push_back('{port, rd, exp_data});
        target  = n_done + 1;
        busy_n  = 0;
        serve_n = 0;
        @(posedge CLK); #1;
        if (!port) begin
            I_ADDRESS = addr;
            I_READ    = 1'b1;
        end else begin
            D_ADDRESS   = addr;
            D_WRITEDATA = wdata;
            D_FUNCT3    = f3;
            D_READ      = rd;
            D_WRITE     = !rd;
        end
        for (int k = 0; k < 40 && n_done < target; k++) begin
            @(negedge CLK); #1;
            if (k == 1) begin
                check({tag, "_mem_rd"}, 32'(MEM_READ), 32'(port ? rd : 1'b1));
                check({tag, "_mem_wr"}, 32'(MEM_WRITE), 32'(port ? !rd : 1'b0));
                check({tag, "_mem_addr"}, MEM_ADDRESS, addr);
                check({tag, "_mem_f3"}, 32'(MEM_FUNCT3), 32'(port ? f3 : 3'b010));
                if (port && !rd) check({tag, "_mem_wdata"}, MEM_WRITEDATA, wdata);
            end
            if (port ? D_BUSYWAIT : I_BUSYWAIT) busy_n++;
            if (MEM_READ || MEM_WRITE) serve_n++;
        end
        check({tag, "_done"}, 32'(n_done >= target), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        check({tag, "_serve_cycles"}, 32'(serve_n), 32'(exp_serve));
        @(posedge CLK); #1;
        // Request still up after DONE is a fresh request, so busywait is back high.
        check({tag, "_rearm"}, 32'(port ? D_BUSYWAIT : I_BUSYWAIT), 32'd1);
        I_READ  = 1'b0;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
    endtask

    initial begin
        int base;
        int lowc;
        RESET = 1'b1;
        I_READ = 1'b0; I_ADDRESS = '0;
        D_READ = 1'b0; D_WRITE = 1'b0; D_FUNCT3 = 3'b101;
        D_ADDRESS = '0; D_WRITEDATA = '0;
        mem_stall = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_mem_read", 32'(MEM_READ), 32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("rst_mem_addr", MEM_ADDRESS, 32'd0);
        check("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        check("rst_mem_f3", 32'(MEM_FUNCT3), 32'd0);
        check("rst_i_rdata", I_READDATA, 32'd0);
        check("rst_d_rdata", D_READDATA, 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_i_bw", 32'(I_BUSYWAIT), 32'd0);
        check("rst_d_bw", 32'(D_BUSYWAIT), 32'd0);

        // Single fetch, then a store/load round trip through the memory, then a sized load.
        run_txn("i_rd", 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 3, 2);
        run_txn("d_wr", 1'b1, 1'b0, 32'h20, 32'h12345678, 3'b010, 32'h0, 3, 2);
        run_txn("d_rd", 1'b1, 1'b1, 32'h20, 32'h0, 3'b010, 32'h12345678, 3, 2);
        run_txn("d_rd_f3", 1'b1, 1'b1, 32'h10, 32'h0, 3'b100, 32'hDEADBEEF, 3, 2);
        run_txn("i_rd2", 1'b0, 1'b1, 32'h24, 32'h0, 3'b010, 32'h09090909, 3, 2);

        // Simultaneous requests held continuously.
        base = n_done;
        @(posedge CLK); #1;
        I_ADDRESS = 32'h10; D_ADDRESS = 32'h20; D_FUNCT3 = 3'b010;
`ifdef MEM_ARB_RR_EN
        sb_q.push_back('{1'b1, 1'b1, 32'h12345678});
        sb_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        sb_q.push_back('{1'b1, 1'b1, 32'h12345678});
        sb_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        I_READ = 1'b1; D_READ = 1'b1;
        wait_done("rr_four_grants", base + 4);
        @(posedge CLK); #1;
        I_READ = 1'b0; D_READ = 1'b0;
`else
        sb_q.push_back('{1'b1, 1'b1, 32'h12345678});
        sb_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        I_READ = 1'b1; D_READ = 1'b1;
        lowc = 0;
        for (int k = 0; k < 40 && n_done < base + 1; k++) begin
            @(negedge CLK); #1;
            if (!I_BUSYWAIT) lowc++;
        end
        check("prio_d_first_done", 32'(n_done - base), 32'd1);
        check("prio_i_stalled", 32'(lowc), 32'd0);
        @(posedge CLK); #1;
        D_READ = 1'b0;
        wait_done("prio_i_after_d", base + 2);
        @(posedge CLK); #1;
        I_READ = 1'b0;
`endif

        // Read and write together: no request, no strobe, no stall.
        @(posedge CLK); #1;
        D_READ = 1'b1; D_WRITE = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); #1;
            check("both_rw_bw", 32'(D_BUSYWAIT), 32'd0);
            check("both_rw_strobe", 32'(MEM_READ | MEM_WRITE), 32'd0);
        end
        D_READ = 1'b0; D_WRITE = 1'b0;

        // Memory never answers: abort after 8 SERVE cycles with zero data and sticky ERR.
        mem_stall = 1'b1;
        run_txn("tmo", 1'b1, 1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 9, 8);
        check("tmo_err", 32'(ERR), 32'd1);
        mem_stall = 1'b0;
        run_txn("post_tmo", 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 3, 2);
        check("err_sticky", 32'(ERR), 32'd1);

        // Asynchronous reset in the middle of SERVE.
        mem_stall = 1'b1;
        @(posedge CLK); #1;
        I_ADDRESS = 32'h10; I_READ = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_pre_strobe", 32'(MEM_READ), 32'd1);
        #2;
        RESET = 1'b1; I_READ = 1'b0;
        #1;
        check("mid_rst_mem_read", 32'(MEM_READ), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(ARB_IDLE));
        check("mid_rst_mem_addr", MEM_ADDRESS, 32'd0);
        check("mid_rst_mem_f3", 32'(MEM_FUNCT3), 32'd0);
        check("mid_rst_i_rdata", I_READDATA, 32'd0);
        check("mid_rst_d_rdata", D_READDATA, 32'd0);
        check("mid_rst_err", 32'(ERR), 32'd0);
        check("mid_rst_i_bw", 32'(I_BUSYWAIT), 32'd0);
        mod_i = '0; mod_d = '0;
        @(posedge CLK); #1;
        mem_stall = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        run_txn("post_rst", 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 3, 2);

        repeat (2) @(posedge CLK);
        check("sb_left", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
